// File: rtl/axi_burst_seq_checker_if.sv
// rtl/axi_burst_seq_checker_if.sv - command/data bundle between the burst sequencer and the traffic generator
//
// master: sequencer side (drives tg_start, tg_w_r, tg_burst_len, tg_addr, tg_data_strb, tg_data_in)
// slave : generator side (drives tg_free, tg_stall_data, tg_status, tg_data_out, tg_data_out_en)

interface axi_burst_seq_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  tg_start;
    logic                  tg_w_r;
    logic [3:0]            tg_burst_len;
    logic [ADDR_W-1:0]     tg_addr;
    logic [DATA_W/8-1:0]   tg_data_strb;
    logic [DATA_W-1:0]     tg_data_in;
    logic                  tg_free;
    logic                  tg_stall_data;
    logic [1:0]            tg_status;
    logic [DATA_W-1:0]     tg_data_out;
    logic                  tg_data_out_en;

    modport master (
        output tg_start, tg_w_r, tg_burst_len, tg_addr, tg_data_strb, tg_data_in,
        input  tg_free, tg_stall_data, tg_status, tg_data_out, tg_data_out_en
    );

    modport slave (
        input  tg_start, tg_w_r, tg_burst_len, tg_addr, tg_data_strb, tg_data_in,
        output tg_free, tg_stall_data, tg_status, tg_data_out, tg_data_out_en
    );
endinterface

// File: rtl/axi_burst_seq_checker.sv
// rtl/axi_burst_seq_checker.sv - writes NUM_BURSTS address-pattern bursts, reads them back and checks them
//
// aclk, aresetn         clock, asynchronous active-low reset
// run                   start pulse (ignored while busy)
// busy, done, pass      run in progress, end-of-run pulse, registered result
// data_err_cnt          mismatched / extra / missing read beats, saturating
// resp_err_cnt          non-OKAY write or read responses, saturating
// tg                    command/data port to the traffic generator (master side)

module axi_burst_seq_checker #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 64,
    parameter int          NUM_BURSTS = 4,
    parameter int          BURST_LEN  = 3,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter logic [31:0] SEED       = 32'hA5A5_0000
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          run,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [15:0]                   data_err_cnt,
    output logic [7:0]                    resp_err_cnt,
    axi_burst_seq_checker_if.master       tg
);

    typedef enum logic [3:0] {
        IDLE, WR_REQ, WR_DATA, WR_RESP, WR_STAT, RD_REQ, RD_DATA, RD_STAT, DONE
    } state_t;

    localparam logic [7:0] LAST_K  = 8'(BURST_LEN);
    localparam logic [7:0] BEATS_K = 8'(BURST_LEN + 1);
    localparam logic [7:0] LAST_B  = 8'(NUM_BURSTS - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  b;
    logic [7:0]  k;
    logic        en_q;
    logic        data_inc;
    logic        resp_inc;
    logic        status_bad;

    function automatic logic [31:0] beat_addr(input logic [7:0] bi, input logic [7:0] ki);
        logic [31:0] idx;
        idx = 32'(bi) * 32'(BURST_LEN + 1) + 32'(ki);
        return BASE_ADDR + idx * 32'(DATA_W / 8);
    endfunction

    function automatic logic [DATA_W-1:0] beat_word(input logic [7:0] bi, input logic [7:0] ki);
        return {(DATA_W / 32){beat_addr(bi, ki) ^ SEED}};
    endfunction

    assign status_bad = (tg.tg_status != 2'b00);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        busy            = (state != IDLE);
        done            = 1'b0;
        data_inc        = 1'b0;
        resp_inc        = 1'b0;
        tg.tg_start     = 1'b0;
        tg.tg_w_r       = 1'b0;
        tg.tg_burst_len = 4'd0;
        tg.tg_addr      = '0;
        tg.tg_data_strb = '0;
        tg.tg_data_in   = '0;
        // Command fields stay valid for the whole run so the generator may sample them late.
        if (state != IDLE) begin
            tg.tg_burst_len = 4'(BURST_LEN);
            tg.tg_addr      = ADDR_W'(beat_addr(b, 8'd0));
        end
        case (state)
            IDLE: begin
                if (run) state_next = WR_REQ;
            end
            WR_REQ: begin
                tg.tg_start     = 1'b1;
                tg.tg_data_in   = beat_word(b, 8'd0);
                tg.tg_data_strb = '1;
                // The generator acknowledges a command by dropping tg_free.
                if (!tg.tg_free) state_next = WR_DATA;
            end
            WR_DATA: begin
                tg.tg_data_in   = beat_word(b, k);
                tg.tg_data_strb = '1;
                if (!tg.tg_stall_data && k == LAST_K) state_next = WR_RESP;
            end
            WR_RESP: begin
                tg.tg_data_in = beat_word(b, LAST_K);
                if (tg.tg_free) state_next = WR_STAT;
            end
            WR_STAT: begin
                resp_inc   = status_bad;
                state_next = (b == LAST_B) ? RD_REQ : WR_REQ;
            end
            RD_REQ: begin
                tg.tg_start = 1'b1;
                tg.tg_w_r   = 1'b1;
                if (!tg.tg_free) state_next = RD_DATA;
            end
            RD_DATA: begin
                if (tg.tg_data_out_en) begin
                    if (k > LAST_K) data_inc = 1'b1;
                    else            data_inc = (tg.tg_data_out != beat_word(b, k));
                end
                // Status lags its beat by one cycle, hence the registered enable.
                resp_inc = en_q & status_bad;
                if (tg.tg_free) state_next = RD_STAT;
            end
            RD_STAT: begin
                resp_inc   = en_q & status_bad;
                data_inc   = (k != BEATS_K);
                state_next = (b == LAST_B) ? DONE : RD_REQ;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            b            <= 8'd0;
            k            <= 8'd0;
            en_q         <= 1'b0;
            pass         <= 1'b0;
            data_err_cnt <= 16'd0;
            resp_err_cnt <= 8'd0;
        end else begin
            en_q <= tg.tg_data_out_en;
            case (state)
                IDLE: begin
                    if (run) begin
                        b            <= 8'd0;
                        pass         <= 1'b0;
                        data_err_cnt <= 16'd0;
                        resp_err_cnt <= 8'd0;
                    end
                end
                WR_REQ, RD_REQ: begin
                    if (!tg.tg_free) k <= 8'd0;
                end
                WR_DATA: begin
                    if (!tg.tg_stall_data) k <= k + 8'd1;
                end
                WR_STAT: begin
                    b <= (b == LAST_B) ? 8'd0 : b + 8'd1;
                end
                RD_DATA: begin
                    // k saturates so a runaway slave cannot wrap it back into range.
                    if (tg.tg_data_out_en && k != 8'hFF) k <= k + 8'd1;
                end
                RD_STAT: begin
                    if (b != LAST_B) b <= b + 8'd1;
                end
                DONE: begin
                    pass <= (data_err_cnt == 16'd0) && (resp_err_cnt == 8'd0);
                end
                default: ;
            endcase
            if (data_inc && data_err_cnt != 16'hFFFF) data_err_cnt <= data_err_cnt + 16'd1;
            if (resp_inc && resp_err_cnt != 8'hFF)    resp_err_cnt <= resp_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_axi_burst_seq_checker.sv
// tb/tb_axi_burst_seq_checker.sv - scoreboard bench with a behavioural generator/slave model

module tb_axi_burst_seq_checker;

    localparam logic [31:0] SEED = 32'hA5A5_0000;

    typedef struct { logic w_r; logic [31:0] addr; } cmd_t;
    typedef struct { int d; int r; logic p; } res_t;
    typedef enum { S_IDLE, S_WDATA, S_WRESP, S_RDATA } sstate_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        run;
    logic        busy, done, pass;
    logic [15:0] data_err_cnt;
    logic [7:0]  resp_err_cnt;

    axi_burst_seq_checker_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    axi_burst_seq_checker #(
        .ADDR_W(32), .DATA_W(64), .NUM_BURSTS(2), .BURST_LEN(3),
        .BASE_ADDR(32'h0000_1000), .SEED(SEED)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .run(run), .busy(busy), .done(done), .pass(pass),
        .data_err_cnt(data_err_cnt), .resp_err_cnt(resp_err_cnt), .tg(bus)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    cmd_t        cq[$];
    logic [63:0] wq[$];
    res_t        res_q[$];
    logic [31:0] wr_addr_log[$];
    logic [63:0] wbeat_log[$];
    logic [63:0] mem [logic [31:0]];

    // Fault/stall knobs for the slave model
    logic stall_mode = 1'b0;
    logic flip_en    = 1'b0;
    int   flip_b = 0, flip_k = 0;
    int   bresp_b = -1, rresp_b = -1, rresp_k = -1, short_b = -1;

    function automatic logic [63:0] pat(input int b, input int k);
        logic [31:0] a;
        a = 32'h1000 + 32'((b * 4 + k) * 8);
        return {a ^ SEED, a ^ SEED};
    endfunction

    // Generator model: everything is decided at the falling edge so the DUT sees stable inputs.
    sstate_t     s_state;
    logic [31:0] s_addr;
    int          s_beat, s_burst, s_nb;
    logic [1:0]  status_next;
    logic [63:0] s_d;
    cmd_t        s_c;

    initial begin
        s_state = S_IDLE;
        status_next = 2'b00;
        bus.tg_free = 1'b1;
        bus.tg_stall_data = 1'b1;
        bus.tg_status = 2'b00;
        bus.tg_data_out = '0;
        bus.tg_data_out_en = 1'b0;
        forever begin
            @(negedge aclk);
            bus.tg_status = status_next;
            status_next = 2'b00;
            bus.tg_data_out_en = 1'b0;
            if (!aresetn) begin
                s_state = S_IDLE;
                bus.tg_free = 1'b1;
                bus.tg_stall_data = 1'b1;
                bus.tg_status = 2'b00;
            end else begin
                case (s_state)
                    S_IDLE: begin
                        bus.tg_stall_data = 1'b1;
                        if (bus.tg_start && (!stall_mode || $urandom_range(1, 0) == 1)) begin
                            check_eq("cmd_avail", cq.size() != 0, 1);
                            if (cq.size() != 0) begin
                                s_c = cq.pop_front();
                                check_eq("cmd_w_r", bus.tg_w_r, s_c.w_r);
                                check_eq("cmd_addr", bus.tg_addr, s_c.addr);
                            end
                            check_eq("cmd_len", bus.tg_burst_len, 3);
                            s_addr  = bus.tg_addr;
                            s_burst = int'((bus.tg_addr - 32'h1000) >> 5);
                            s_beat  = 0;
                            bus.tg_free = 1'b0;
                            if (!bus.tg_w_r) begin
                                wr_addr_log.push_back(s_addr);
                                s_state = S_WDATA;
                            end else begin
                                s_state = S_RDATA;
                            end
                        end
                    end
                    S_WDATA: begin
                        bus.tg_stall_data = stall_mode && ($urandom_range(1, 0) == 1);
                        if (!bus.tg_stall_data) begin
                            check_eq("wstrb", bus.tg_data_strb, 64'hFF);
                            check_eq("wbeat_avail", wq.size() != 0, 1);
                            if (wq.size() != 0) check_eq("wbeat", bus.tg_data_in, wq.pop_front());
                            mem[s_addr + 32'(s_beat * 8)] = bus.tg_data_in;
                            wbeat_log.push_back(bus.tg_data_in);
                            s_beat++;
                            if (s_beat == 4) s_state = S_WRESP;
                        end
                    end
                    S_WRESP: begin
                        bus.tg_stall_data = 1'b1;
                        if (!stall_mode || $urandom_range(1, 0) == 1) begin
                            bus.tg_free = 1'b1;
                            status_next = (s_burst == bresp_b) ? 2'b10 : 2'b00;
                            s_state = S_IDLE;
                        end
                    end
                    S_RDATA: begin
                        if (!stall_mode || $urandom_range(1, 0) == 1) begin
                            s_nb = (s_burst == short_b) ? 3 : 4;
                            s_d = mem.exists(s_addr + 32'(s_beat * 8)) ? mem[s_addr + 32'(s_beat * 8)] : 64'd0;
                            if (flip_en && s_burst == flip_b && s_beat == flip_k) s_d[0] = ~s_d[0];
                            bus.tg_data_out = s_d;
                            bus.tg_data_out_en = 1'b1;
                            status_next = (s_burst == rresp_b && s_beat == rresp_k) ? 2'b11 : 2'b00;
                            s_beat++;
                            if (s_beat == s_nb) begin
                                bus.tg_free = 1'b1;
                                s_state = S_IDLE;
                            end
                        end
                    end
                    default: s_state = S_IDLE;
                endcase
            end
        end
    end

    task automatic start_run(input int exp_d, input int exp_r, input logic exp_p);
        res_t e;
        wr_addr_log.delete();
        wbeat_log.delete();
        for (int b = 0; b < 2; b++) cq.push_back('{1'b0, 32'h1000 + 32'(b * 32)});
        for (int b = 0; b < 2; b++) cq.push_back('{1'b1, 32'h1000 + 32'(b * 32)});
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 4; k++) wq.push_back(pat(b, k));
        e.d = exp_d; e.r = exp_r; e.p = exp_p;
        res_q.push_back(e);
        @(negedge aclk);
        run = 1'b1;
    endtask

    task automatic wait_done(input string tag, input logic poke);
        logic seen;
        res_t e;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge aclk);
            run = poke && (i == 10);
            if (done) seen = 1'b1;
        end
        run = 1'b0;
        check_eq({tag, "_done_seen"}, seen, 1);
        if (seen && res_q.size() != 0) begin
            e = res_q.pop_front();
            check_eq({tag, "_data_err"}, data_err_cnt, 64'(e.d));
            check_eq({tag, "_resp_err"}, resp_err_cnt, 64'(e.r));
            check_eq({tag, "_wq_left"}, wq.size(), 0);
            check_eq({tag, "_cq_left"}, cq.size(), 0);
            @(negedge aclk);
            check_eq({tag, "_pass"}, pass, e.p);
            check_eq({tag, "_done_1cyc"}, done, 0);
            check_eq({tag, "_busy_end"}, busy, 0);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_derr"}, data_err_cnt, 0);
        check_eq({tag, "_rerr"}, resp_err_cnt, 0);
        check_eq({tag, "_start"}, bus.tg_start, 0);
        check_eq({tag, "_strb"}, bus.tg_data_strb, 0);
        check_eq({tag, "_addr"}, bus.tg_addr, 0);
        check_eq({tag, "_din"}, bus.tg_data_in, 0);
    endtask

    initial begin
        logic seen;
        aresetn = 1'b0;
        run = 1'b0;
        repeat (3) @(negedge aclk);
        check_quiet("rst");
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Ideal slave; a run pulse while busy must change nothing.
        start_run(0, 0, 1'b1);
        wait_done("ideal", 1'b1);
        check_eq("first_wbeat", (wbeat_log.size() != 0) ? wbeat_log[0] : 64'd0, 64'hA5A51000_A5A51000);
        check_eq("burst1_addr", (wr_addr_log.size() > 1) ? wr_addr_log[1] : 32'd0, 32'h0000_1020);

        flip_en = 1'b1; flip_b = 1; flip_k = 2;
        start_run(1, 0, 1'b0);
        wait_done("flip", 1'b0);
        flip_en = 1'b0;

        bresp_b = 0; rresp_b = 1; rresp_k = 1;
        start_run(0, 2, 1'b0);
        wait_done("resp", 1'b0);
        bresp_b = -1; rresp_b = -1; rresp_k = -1;

        stall_mode = 1'b1;
        start_run(0, 0, 1'b1);
        wait_done("stall", 1'b0);
        check_eq("stall_wbeats", wbeat_log.size(), 8);
        stall_mode = 1'b0;

        // Abort in the read phase, then a clean run.
        start_run(0, 0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge aclk);
            run = 1'b0;
            if (bus.tg_start && bus.tg_w_r) seen = 1'b1;
        end
        check_eq("rd_phase_seen", seen, 1);
        repeat (3) @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        check_quiet("midrst");
        cq.delete(); wq.delete(); res_q.delete(); mem.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        start_run(0, 0, 1'b1);
        wait_done("rerun", 1'b0);

        short_b = 0;
        start_run(1, 0, 1'b0);
        wait_done("short", 1'b0);
        short_b = -1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
